rp_acq_trig_ctrl: RTL and testbench

//  Acquisition trigger sequencer in the ADC clock domain. Selects one trigger source from the

---
 rtl/rp_trig_pkg.sv | 25 ++
 rtl/rp_trig_src_mux.sv | 54 +++++
 rtl/rp_acq_trig_ctrl.sv | 148 ++++++++++++++
 tb/tb_rp_acq_trig_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rp_trig_pkg.sv
// Shared definitions for the acquisition trigger sequencer: state encoding,
// trigger source select codes and default widths.
package rp_trig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] SRC_OFF   = 3'd0;
  localparam logic [2:0] SRC_SW    = 3'd1;
  localparam logic [2:0] SRC_LVL_P = 3'd2;
  localparam logic [2:0] SRC_LVL_N = 3'd3;
  localparam logic [2:0] SRC_EXT_P = 3'd4;
  localparam logic [2:0] SRC_EXT_N = 3'd5;
  localparam logic [2:0] SRC_ASG_P = 3'd6;
  localparam logic [2:0] SRC_ASG_N = 3'd7;

  localparam int unsigned CW_DEF = 32;
  localparam int unsigned AW_DEF = 14;

endpackage

// File: rtl/rp_trig_src_mux.sv
// Registered 8:1 trigger event selector. The event and the source code that
// produced it are registered together, so a change of src_sel_i can never
// pair an old event with a new code or create a spurious pulse.
module rp_trig_src_mux
  import rp_trig_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       ext_trig_p_i,
  input  logic       ext_trig_n_i,
  input  logic       asg_trig_p_i,
  input  logic       asg_trig_n_i,
  input  logic       lvl_trig_p_i,
  input  logic       lvl_trig_n_i,
  input  logic       sw_trig_i,
  input  logic [2:0] src_sel_i,
  output logic       evt_o,
  output logic [2:0] evt_src_o
);

  logic       w_evt;
  logic       r_evt;
  logic [2:0] r_src;

  // Pick the event of the currently selected source; code 0 never fires.
  always_comb begin
    w_evt = 1'b0;
    case (src_sel_i)
      SRC_SW:    w_evt = sw_trig_i;
      SRC_LVL_P: w_evt = lvl_trig_p_i;
      SRC_LVL_N: w_evt = lvl_trig_n_i;
      SRC_EXT_P: w_evt = ext_trig_p_i;
      SRC_EXT_N: w_evt = ext_trig_n_i;
      SRC_ASG_P: w_evt = asg_trig_p_i;
      SRC_ASG_N: w_evt = asg_trig_n_i;
      default:   w_evt = 1'b0;
    endcase
  end

  // Register the selected event together with its source code.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_evt <= 1'b0;
      r_src <= SRC_OFF;
    end else begin
      r_evt <= w_evt;
      r_src <= src_sel_i;
    end
  end

  assign evt_o     = r_evt;
  assign evt_src_o = r_src;

endmodule

// File: rtl/rp_acq_trig_ctrl.sv
// Acquisition trigger sequencer: IDLE -> PRE -> ARMED -> POST -> DONE with
// optional auto re-arm after a hold-off. One down-counter is shared by the
// pre-trigger, post-trigger and hold-off phases; a free-running address
// counter advances on every buffer write.
module rp_acq_trig_ctrl
  import rp_trig_pkg::*;
#(
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          adc_clk_i,
  input  logic          adc_rstn_i,
  input  logic          ext_trig_p_i,
  input  logic          ext_trig_n_i,
  input  logic          asg_trig_p_i,
  input  logic          asg_trig_n_i,
  input  logic          lvl_trig_p_i,
  input  logic          lvl_trig_n_i,
  input  logic          sw_trig_i,
  input  logic [2:0]    src_sel_i,
  input  logic          arm_i,
  input  logic          abort_i,
  input  logic          auto_i,
  input  logic [CW-1:0] pre_len_i,
  input  logic [CW-1:0] post_len_i,
  input  logic [CW-1:0] holdoff_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic          trig_o,
  output logic [AW-1:0] trig_addr_o,
  output logic [2:0]    trig_src_o,
  output logic [2:0]    state_o,
  output logic          done_o
);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_trig_addr;
  logic [2:0]    r_trig_src;
  logic          w_evt;
  logic [2:0]    w_evt_src;
  logic          w_start;
  logic          w_accept;
  logic          w_cnt_last;
  logic          w_wr_en;

  rp_trig_src_mux u_src_mux (
    .clk_i        (adc_clk_i),
    .rstn_i       (adc_rstn_i),
    .ext_trig_p_i (ext_trig_p_i),
    .ext_trig_n_i (ext_trig_n_i),
    .asg_trig_p_i (asg_trig_p_i),
    .asg_trig_n_i (asg_trig_n_i),
    .lvl_trig_p_i (lvl_trig_p_i),
    .lvl_trig_n_i (lvl_trig_n_i),
    .sw_trig_i    (sw_trig_i),
    .src_sel_i    (src_sel_i),
    .evt_o        (w_evt),
    .evt_src_o    (w_evt_src)
  );

  // Counter at 0 or 1 means the current phase ends this cycle; hold-off 0 and
  // 1 both give a single DONE cycle.
  assign w_cnt_last = (r_cnt <= CW'(1));
  // A new acquisition starts on arm (IDLE/DONE) or when auto hold-off expires.
  assign w_start    = !abort_i &&
                      ((((r_state == ST_IDLE) || (r_state == ST_DONE)) && arm_i) ||
                       ((r_state == ST_DONE) && auto_i && w_cnt_last));
  assign w_accept   = !abort_i && (r_state == ST_ARMED) && w_evt;

  // State register.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) r_state <= ST_IDLE;
    else             r_state <= w_next;
  end

  // Next-state logic; abort beats arm, arm beats trigger.
  always_comb begin
    w_next = r_state;
    if (abort_i) begin
      w_next = ST_IDLE;
    end else if (w_start) begin
      w_next = (pre_len_i == '0) ? ST_ARMED : ST_PRE;
    end else begin
      case (r_state)
        ST_PRE:   if (w_cnt_last) w_next = ST_ARMED;
        ST_ARMED: if (w_evt) w_next = (post_len_i == '0) ? ST_DONE : ST_POST;
        ST_POST:  if (w_cnt_last) w_next = ST_DONE;
        default:  w_next = r_state;
      endcase
    end
  end

  // Outputs decoded from state; abort gates the write in its own cycle.
  always_comb begin
    w_wr_en = !abort_i &&
              ((r_state == ST_PRE) || (r_state == ST_ARMED) || (r_state == ST_POST));
    trig_o  = w_accept;
    done_o  = (r_state == ST_DONE);
  end

  // Shared phase counter: loaded with the length of each phase on its entry.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_cnt <= '0;
    end else if (abort_i) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= pre_len_i;
    end else if (w_accept && (post_len_i != '0)) begin
      r_cnt <= post_len_i;
    end else if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
      r_cnt <= holdoff_i;
    end else if ((r_state == ST_PRE) || (r_state == ST_POST)) begin
      r_cnt <= r_cnt - CW'(1);
    end else if ((r_state == ST_DONE) && auto_i && !w_cnt_last) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Write address and trigger capture; both cleared when an acquisition starts.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_addr      <= '0;
      r_trig_addr <= '0;
      r_trig_src  <= SRC_OFF;
    end else if (w_start) begin
      r_addr      <= '0;
      r_trig_addr <= '0;
      r_trig_src  <= SRC_OFF;
    end else begin
      if (w_wr_en) r_addr <= r_addr + AW'(1);
      if (w_accept) begin
        r_trig_addr <= r_addr;
        r_trig_src  <= w_evt_src;
      end
    end
  end

  assign wr_en_o     = w_wr_en;
  assign wr_addr_o   = r_addr;
  assign trig_addr_o = r_trig_addr;
  assign trig_src_o  = r_trig_src;
  assign state_o     = r_state;

endmodule

// File: tb/tb_rp_acq_trig_ctrl.sv
// Directed bench for rp_acq_trig_ctrl (AW=4 so address wrap is reachable).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge of the same cycle.
module tb_rp_acq_trig_ctrl;

  localparam int CW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ext_p, ext_n, asg_p, asg_n, lvl_p, lvl_n, sw;
  logic [2:0]    src_sel;
  logic          arm, abort, auto_en;
  logic [CW-1:0] pre_len, post_len, holdoff;
  logic          wr_en_o, trig_o, done_o;
  logic [AW-1:0] wr_addr_o, trig_addr_o;
  logic [2:0]    trig_src_o, state_o;

  int checks = 0;
  int errors = 0;

  // cycle statistics
  int n_trig, n_wr, n_wr_post, n_pre;
  int addr_at_trig;
  int done_run, done_runs, done_min, done_max;
  int s_state, s_wr_en, s_addr, s_trig, s_trig_addr, s_trig_src, s_done;

  rp_acq_trig_ctrl #(.CW(CW), .AW(AW)) dut (
    .adc_clk_i    (clk),
    .adc_rstn_i   (rstn),
    .ext_trig_p_i (ext_p),
    .ext_trig_n_i (ext_n),
    .asg_trig_p_i (asg_p),
    .asg_trig_n_i (asg_n),
    .lvl_trig_p_i (lvl_p),
    .lvl_trig_n_i (lvl_n),
    .sw_trig_i    (sw),
    .src_sel_i    (src_sel),
    .arm_i        (arm),
    .abort_i      (abort),
    .auto_i       (auto_en),
    .pre_len_i    (pre_len),
    .post_len_i   (post_len),
    .holdoff_i    (holdoff),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .trig_o       (trig_o),
    .trig_addr_o  (trig_addr_o),
    .trig_src_o   (trig_src_o),
    .state_o      (state_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_trig = 0; n_wr = 0; n_wr_post = 0; n_pre = 0; addr_at_trig = -1;
    done_run = 0; done_runs = 0; done_min = 1000; done_max = 0;
  endtask

  // One clock cycle with the current inputs; sample mid-cycle.
  task automatic tick();
    @(negedge clk);
    s_state = int'(state_o); s_wr_en = int'(wr_en_o); s_addr = int'(wr_addr_o);
    s_trig = int'(trig_o); s_trig_addr = int'(trig_addr_o);
    s_trig_src = int'(trig_src_o); s_done = int'(done_o);
    if (trig_o) begin n_trig++; addr_at_trig = int'(wr_addr_o); end
    if (wr_en_o) n_wr++;
    if (wr_en_o && state_o == 3'd3) n_wr_post++;
    if (state_o == 3'd1) n_pre++;
    if (state_o == 3'd4) done_run++;
    else if (done_run > 0) begin
      done_runs++;
      if (done_run < done_min) done_min = done_run;
      if (done_run > done_max) done_max = done_run;
      done_run = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rstn = 1'b0; ext_p = 0; ext_n = 0; asg_p = 0; asg_n = 0; lvl_p = 0; lvl_n = 0;
    sw = 0; src_sel = 3'd0; arm = 0; abort = 0; auto_en = 0;
    pre_len = '0; post_len = '0; holdoff = '0;
    clear_stats();

    // Reset values
    ticks(2);
    check("rst_state", s_state, 0);
    check("rst_wr_en", s_wr_en, 0);
    check("rst_wr_addr", s_addr, 0);
    check("rst_trig", s_trig, 0);
    check("rst_trig_addr", s_trig_addr, 0);
    check("rst_trig_src", s_trig_src, 0);
    check("rst_done", s_done, 0);
    rstn = 1'b1;
    tick();

    // 1: pre=4 post=3 src=ext_p, pulse 10 cycles after arm
    pre_len = 4; post_len = 3; src_sel = 3'd4;
    arm = 1; tick(); arm = 0;
    clear_stats();
    ticks(9);
    ext_p = 1; tick(); ext_p = 0;
    ticks(8);
    check("t1_pre_cycles", n_pre, 4);
    check("t1_trig_count", n_trig, 1);
    check("t1_addr_at_trig", addr_at_trig, 10);
    check("t1_trig_addr", s_trig_addr, 10);
    check("t1_post_writes", n_wr_post, 3);
    check("t1_total_writes", n_wr, 14);
    check("t1_trig_src", s_trig_src, 4);
    check("t1_state", s_state, 4);
    check("t1_done", s_done, 1);
    check("t1_wr_en_done", s_wr_en, 0);
    check("t1_wr_addr", s_addr, 14);

    // 2: pre=8, pulse in PRE cycle 3 is dropped; pulse in ARMED triggers
    pre_len = 8; post_len = 2;
    arm = 1; tick(); arm = 0;
    clear_stats();
    tick();
    check("t2_trig_src_cleared", s_trig_src, 0);
    check("t2_trig_addr_cleared", s_trig_addr, 0);
    tick();
    ext_p = 1; tick(); ext_p = 0;
    ticks(8);
    check("t2_no_trig_in_pre", n_trig, 0);
    check("t2_armed", s_state, 2);
    ext_p = 1; tick(); ext_p = 0;
    ticks(6);
    check("t2_trig_count", n_trig, 1);
    check("t2_trig_addr", s_trig_addr, 12);
    check("t2_trig_src", s_trig_src, 4);
    check("t2_state", s_state, 4);
    check("t2_wr_addr", s_addr, 15);

    // 3: pre=20 with AW=4, address wraps 15 -> 0
    pre_len = 20; post_len = 2; src_sel = 3'd1;
    arm = 1; tick(); arm = 0;
    clear_stats();
    ticks(16);
    check("t3_addr_15", s_addr, 15);
    tick();
    check("t3_addr_wrap", s_addr, 0);
    check("t3_wr_en_wrap", s_wr_en, 1);
    check("t3_state_pre", s_state, 1);
    ticks(4);
    sw = 1; tick(); sw = 0;
    ticks(5);
    check("t3_trig_count", n_trig, 1);
    check("t3_trig_addr", s_trig_addr, 6);
    check("t3_trig_src", s_trig_src, 1);
    check("t3_state", s_state, 4);

    // 4: auto re-arm, holdoff=5, sw held high so every ARMED entry triggers
    pre_len = 2; post_len = 1; holdoff = 5;
    arm = 1; auto_en = 1; tick(); arm = 0;
    clear_stats();
    sw = 1;
    ticks(27);
    check("t4_state_done", s_state, 4);
    tick();
    check("t4_state_pre", s_state, 1);
    check("t4_trig_count", n_trig, 3);
    check("t4_done_runs", done_runs, 3);
    check("t4_done_min", done_min, 5);
    check("t4_done_max", done_max, 5);
    ticks(4);
    check("t4_done_again", s_state, 4);
    auto_en = 0;
    ticks(10);
    check("t4_auto_off_stay", s_state, 4);
    check("t4_trig_total", n_trig, 4);
    sw = 0;

    // 5: abort and arm together during POST
    pre_len = 1; post_len = 6;
    arm = 1; tick(); arm = 0;
    clear_stats();
    tick();
    sw = 1; tick(); sw = 0;
    ticks(2);
    check("t5_trig_addr", s_trig_addr, 2);
    abort = 1; arm = 1; tick(); abort = 0; arm = 0;
    check("t5_state_post", s_state, 3);
    check("t5_wr_en_abort", s_wr_en, 0);
    sw = 1;
    ticks(10);
    sw = 0;
    check("t5_state_idle", s_state, 0);
    check("t5_wr_en_idle", s_wr_en, 0);
    check("t5_trig_count", n_trig, 1);
    check("t5_wr_addr", s_addr, 4);

    // 6: pre=0 post=0 src=asg_p, event registered into the first ARMED cycle
    pre_len = 0; post_len = 0; src_sel = 3'd6;
    tick();
    arm = 1; asg_p = 1; tick(); arm = 0; asg_p = 0;
    clear_stats();
    tick();
    check("t6_trig_armed", s_trig, 1);
    check("t6_state_armed", s_state, 2);
    tick();
    check("t6_state_done", s_state, 4);
    tick();
    check("t6_trig_count", n_trig, 1);
    check("t6_writes", n_wr, 1);
    check("t6_trig_addr", s_trig_addr, 0);
    check("t6_trig_src", s_trig_src, 6);
    check("t6_wr_addr", s_addr, 1);

    // Asynchronous reset in the middle of PRE
    pre_len = 5; src_sel = 3'd0;
    arm = 1; tick(); arm = 0;
    ticks(2);
    check("ar_state_before", int'(state_o), 1);
    check("ar_addr_before", int'(wr_addr_o), 2);
    rstn = 1'b0; #1;
    check("ar_state", int'(state_o), 0);
    check("ar_wr_en", int'(wr_en_o), 0);
    check("ar_wr_addr", int'(wr_addr_o), 0);
    check("ar_trig_src", int'(trig_src_o), 0);
    check("ar_done", int'(done_o), 0);
    tick();
    rstn = 1'b1;
    tick();
    check("ar_idle_after", s_state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
